fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage for the RISC-V core. It sits directly upstream of the instruction memory and drives that memory's fetch address. It captures the returned instruction word together with its PC into a 2-entry buffer, and presents fetched instructions to decode over a valid/ready handshake. Control-flow redirects from execute flush the buffer and restart fetch at the target.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- NOP_INSTR, 32'h0000_0013: instruction value driven on if_instr while the buffer is empty.
- clk  input  1  core clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- imem_addr  output  32  byte address to instruction memory.
- imem_instr  input  32  instruction word returned combinationally for imem_addr in the same cycle.
- redirect_valid  input  1  branch/jump taken; flush and refetch.
- redirect_pc  input  32  redirect target byte address.
- if_valid  output  1  buffer head holds a valid instruction.
- if_ready  input  1  decode accepts the head this cycle.
- if_instr  output  32  head instruction word.
- if_pc  output  32  PC of head instruction.
- if_pc_plus4  output  32  if_pc + 4, modulo 2^32.

## Operation
- State:
  - pc_q (32b);
  - 2-entry circular buffer of {pc, instr}, 64b per entry;
  - rd_ptr and wr_ptr (1b each);
  - count (2b, range 0..2).
- imem_addr = pc_q. Combinational, no register.
- pop = if_valid && if_ready.
- fetch_en = !redirect_valid && (count < 2 || pop).
- On fetch_en:
  - write {pc_q, imem_instr} at wr_ptr, then wr_ptr toggles;
  - pc_q <= pc_q + 4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
- On pop without redirect: rd_ptr toggles.
- count next value: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Redirect has priority over fetch and pop:
  - count <= 0; rd_ptr and wr_ptr <= 0;
  - pc_q <= {redirect_pc[31:2], 2'b00}, so the low two bits are forced to zero;
  - no push occurs that cycle;
  - a head accepted by decode in the redirect cycle counts as delivered; the buffer is still flushed.
- Outputs:
  - if_valid = (count != 0).
  - When count != 0: if_instr and if_pc come from the entry at rd_ptr.
  - When count == 0: if_instr = NOP_INSTR and if_pc = 0, so if_pc_plus4 = 4.
- Entries leave in fetch order. The buffer never overwrites an unread entry: a push while full requires a same-cycle pop.

## Timing
- Reset, asynchronous and immediate on rst_n low:
  - pc_q = RESET_PC; count = 0; rd_ptr = wr_ptr = 0;
  - therefore if_valid = 0, if_instr = NOP_INSTR, if_pc = 0, if_pc_plus4 = 4, imem_addr = RESET_PC.
- Reset asserted mid-operation discards all buffered instructions with no further handshake.
- First edge after reset release (cycle 0):
  - the instruction at RESET_PC is captured;
  - if_valid = 1 from cycle 1.
- Fetch-to-decode latency is 1 cycle.
- With if_ready held high, throughput is 1 instruction per cycle, with no bubbles in steady state.
- Backpressure:
  - with if_ready = 0, the buffer fills in 2 cycles;
  - pc_q then holds and imem_addr is stable;
  - if_instr and if_pc stay stable while if_valid && !if_ready.
- After if_ready rises on a full buffer, fetch resumes in the same cycle because push and pop occur together.
- Redirect:
  - redirect_valid in cycle N: if_valid = 0 in N+1, and imem_addr = target in N+1;
  - the target instruction appears at the head in N+2.
- Back-to-back redirects: each one re-flushes, and the last target wins.

## Test plan
- Reset release, if_ready = 1, memory holds 0x00500093, 0x00600113, 0x002081B3 at 0x0, 0x4, 0x8 -> if_valid from cycle 1; if_pc sequence 0x0, 0x4, 0x8, each paired with its word; if_pc_plus4 = if_pc + 4.
- Hold if_ready = 0 for 5 cycles after reset -> count saturates at 2; imem_addr stays at 0x8; head stays pc 0x0 / 0x00500093. Raise if_ready -> pcs 0x0, 0x4, 0x8, 0xC delivered with no duplicates or gaps.
- redirect_valid with redirect_pc = 0x0000_0102 while buffer full -> next cycle if_valid = 0 and imem_addr = 0x100; following cycle head pc = 0x100.
- Redirect to 0xFFFF_FFFC, if_ready = 1 -> pcs 0xFFFF_FFFC then 0x0; if_pc_plus4 = 0x0 for the first.
- Assert rst_n low asynchronously mid-stream with buffer holding 2 entries -> immediately if_valid = 0, if_instr = 0x00000013, imem_addr = RESET_PC; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction memory address, captures
// {pc, instr} into a 2-entry buffer and hands the head to decode over a
// valid/ready handshake. A redirect flushes the buffer and restarts fetch.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4
);

   logic [31:0] pc_q;
   logic [31:0] buf_pc    [2];
   logic [31:0] buf_instr [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  count;
   logic        pop;
   logic        fetch_en;

   assign imem_addr = pc_q;
   assign if_valid  = (count != 2'd0);
   assign pop       = if_valid && if_ready;
   // A full buffer may still fetch when the head leaves in the same cycle.
   assign fetch_en  = !redirect_valid && ((count != 2'd2) || pop);

   // Head presentation; an empty buffer shows a NOP at pc 0.
   always_comb begin
      if_instr = NOP_INSTR;
      if_pc    = 32'h0000_0000;
      if (if_valid) begin
         if_instr = buf_instr[rd_ptr];
         if_pc    = buf_pc[rd_ptr];
      end
   end

   assign if_pc_plus4 = if_pc + 32'd4;

   // Buffer storage; entries are only meaningful while counted, so no reset.
   always_ff @(posedge clk) begin
      if (fetch_en) begin
         buf_pc[wr_ptr]    <= pc_q;
         buf_instr[wr_ptr] <= imem_instr;
      end
   end

   // Fetch PC, pointers and occupancy; redirect overrides fetch and pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= RESET_PC;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (redirect_valid) begin
         pc_q   <= {redirect_pc[31:2], 2'b00};
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (fetch_en) begin
            wr_ptr <= ~wr_ptr;
            pc_q   <= pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({fetch_en, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run checked
// against a queue-based model of the fetch buffer.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;

   int n_checks = 0;
   int n_fail   = 0;

   // model: queue of {pc, instr} and the next fetch address
   logic [63:0] mq[$];
   logic [31:0] mpc;

   fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_pc_plus4    (if_pc_plus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0050_0093;
         32'h0000_0004: return 32'h0060_0113;
         32'h0000_0008: return 32'h0020_81B3;
         default:       return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
      endcase
   endfunction

   assign imem_instr = mem_word(imem_addr);

   // Drive one cycle's inputs at the falling edge, advance the model by the
   // handshake rules, then return at the next falling edge.
   task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
      logic pop;
      int   occ;
      if_ready       = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      occ = mq.size();
      pop = (occ != 0) && rdy;
      if (rv) begin
         mq.delete();
         mpc = rpc & 32'hFFFF_FFFC;
      end else begin
         if (pop) void'(mq.pop_front());
         if (occ < 2 || pop) begin
            mq.push_back({mpc, mem_word(mpc)});
            mpc = mpc + 32'd4;
         end
      end
      @(posedge clk);
      @(negedge clk);
      redirect_valid = 1'b0;
   endtask

   task automatic model_reset();
      mq.delete();
      mpc = RESET_PC;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      model_reset();
      repeat (2) @(negedge clk);
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
      n_checks++; if (if_instr !== NOP_INSTR) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", if_instr, NOP_INSTR); end
      n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", if_pc); end
      n_checks++; if (if_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc_plus4: got %h expected 4", if_pc_plus4); end
      n_checks++; if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_imem_addr: got %h expected %h", imem_addr, RESET_PC); end
      rst_n = 1'b1;
   endtask

   task automatic test_stream();
      logic [31:0] exp_pc [3];
      logic [31:0] exp_in [3];
      exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
      exp_in[0] = 32'h0050_0093; exp_in[1] = 32'h0060_0113; exp_in[2] = 32'h0020_81B3;
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL stream_pre_valid: got %b expected 0", if_valid); end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, 32'h0);
         n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, if_valid); end
         n_checks++; if (if_pc !== exp_pc[i]) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, if_pc, exp_pc[i]); end
         n_checks++; if (if_instr !== exp_in[i]) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, if_instr, exp_in[i]); end
         n_checks++; if (if_pc_plus4 !== exp_pc[i] + 32'd4) begin n_fail++; $display("FAIL stream_pc_plus4[%0d]: got %h expected %h", i, if_pc_plus4, exp_pc[i] + 32'd4); end
      end
   endtask

   task automatic test_async_reset();
      cycle(1'b0, 1'b0, 32'h0);
      n_checks++; if (mq.size() != 2 || if_valid !== 1'b1) begin n_fail++; $display("FAIL areset_prefull: valid %b model depth %0d expected valid with 2 entries", if_valid, mq.size()); end
      #3;
      rst_n = 1'b0;
      #1;
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b expected 0", if_valid); end
      n_checks++; if (if_instr !== NOP_INSTR) begin n_fail++; $display("FAIL areset_instr: got %h expected %h", if_instr, NOP_INSTR); end
      n_checks++; if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL areset_imem_addr: got %h expected %h", imem_addr, RESET_PC); end
      model_reset();
      if_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_addr [5];
      logic [31:0] seen [$];
      exp_addr[0] = 32'h4; exp_addr[1] = 32'h8; exp_addr[2] = 32'h8; exp_addr[3] = 32'h8; exp_addr[4] = 32'h8;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b0, 32'h0);
         n_checks++; if (imem_addr !== exp_addr[i]) begin n_fail++; $display("FAIL bp_imem_addr[%0d]: got %h expected %h", i, imem_addr, exp_addr[i]); end
         n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h0050_0093) begin
            n_fail++; $display("FAIL bp_head[%0d]: got valid %b pc %h instr %h expected 1/0/00500093", i, if_valid, if_pc, if_instr);
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (if_valid === 1'b1) seen.push_back(if_pc);
         cycle(1'b1, 1'b0, 32'h0);
      end
      n_checks++; if (seen.size() != 4) begin n_fail++; $display("FAIL bp_drain_count: got %0d expected 4", seen.size()); end
      for (int i = 0; i < seen.size(); i++) begin
         n_checks++; if (seen[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL bp_drain_pc[%0d]: got %h expected %h", i, seen[i], 32'(4 * i)); end
      end
   endtask

   task automatic test_redirect();
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 32'h0000_0102);
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %b expected 0", if_valid); end
      n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_imem_addr: got %h expected 00000100", imem_addr); end
      cycle(1'b0, 1'b0, 32'h0);
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin n_fail++; $display("FAIL redir_head: got valid %b pc %h expected 1/00000100", if_valid, if_pc); end
      n_checks++; if (if_instr !== mem_word(32'h100)) begin n_fail++; $display("FAIL redir_instr: got %h expected %h", if_instr, mem_word(32'h100)); end
   endtask

   task automatic test_wrap();
      cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
      n_checks++; if (if_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_redir: got valid %b addr %h expected 0/fffffffc", if_valid, imem_addr); end
      cycle(1'b1, 1'b0, 32'h0);
      n_checks++; if (if_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc0: got %h expected fffffffc", if_pc); end
      n_checks++; if (if_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc_plus4: got %h expected 00000000", if_pc_plus4); end
      n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_imem_addr: got %h expected 00000000", imem_addr); end
      cycle(1'b1, 1'b0, 32'h0);
      n_checks++; if (if_pc !== 32'h0 || if_instr !== 32'h0050_0093) begin n_fail++; $display("FAIL wrap_pc1: got pc %h instr %h expected 0/00500093", if_pc, if_instr); end
   endtask

   task automatic test_back_to_back();
      cycle(1'b1, 1'b1, 32'h0000_0200);
      cycle(1'b1, 1'b1, 32'h0000_0307);
      n_checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h304) begin n_fail++; $display("FAIL b2b_redir: got valid %b addr %h expected 0/00000304", if_valid, imem_addr); end
      cycle(1'b0, 1'b0, 32'h0);
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h304) begin n_fail++; $display("FAIL b2b_head: got valid %b pc %h expected 1/00000304", if_valid, if_pc); end
   endtask

   task automatic test_random();
      logic [31:0] e_pc;
      logic [31:0] e_in;
      for (int i = 0; i < 400; i++) begin
         e_pc = (mq.size() != 0) ? mq[0][63:32] : 32'h0;
         e_in = (mq.size() != 0) ? mq[0][31:0]  : NOP_INSTR;
         n_checks++; if (if_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, if_valid, mq.size() != 0); end
         n_checks++; if (if_pc !== e_pc) begin n_fail++; $display("FAIL rand_pc[%0d]: got %h expected %h", i, if_pc, e_pc); end
         n_checks++; if (if_instr !== e_in) begin n_fail++; $display("FAIL rand_instr[%0d]: got %h expected %h", i, if_instr, e_in); end
         n_checks++; if (if_pc_plus4 !== e_pc + 32'd4) begin n_fail++; $display("FAIL rand_pc_plus4[%0d]: got %h expected %h", i, if_pc_plus4, e_pc + 32'd4); end
         n_checks++; if (imem_addr !== mpc) begin n_fail++; $display("FAIL rand_imem_addr[%0d]: got %h expected %h", i, imem_addr, mpc); end
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_async_reset();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
